// File: rtl/fpu_issue_arbiter.sv
// Shares one FPU between NUM_REQ issue sources: round-robin issue, ROB-tag routing of results.
// Optional LEN5_FPU_ARB_STATS_EN adds per-requester grant counters and a table-full cycle counter.
module fpu_issue_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned EU_CTL_LEN      = 4,
    parameter int unsigned FRM_LEN         = 3,
    parameter int unsigned ROB_IDX_LEN     = 6,
    parameter int unsigned FLEN            = 64,
    parameter int unsigned FFLAGS_LEN      = 5
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic [NUM_REQ-1:0]                     req_valid_i,
    output logic [NUM_REQ-1:0]                     req_ready_o,
    input  logic [NUM_REQ-1:0][EU_CTL_LEN-1:0]     req_ctl_i,
    input  logic [NUM_REQ-1:0][FRM_LEN-1:0]        req_rm_i,
    input  logic [NUM_REQ-1:0][ROB_IDX_LEN-1:0]    req_rob_idx_i,
    input  logic [NUM_REQ-1:0][FLEN-1:0]           req_rs1_i,
    input  logic [NUM_REQ-1:0][FLEN-1:0]           req_rs2_i,
    input  logic [NUM_REQ-1:0][FLEN-1:0]           req_rs3_i,
    output logic                                   fpu_valid_o,
    input  logic                                   fpu_ready_i,
    output logic [EU_CTL_LEN-1:0]                  fpu_ctl_o,
    output logic [FRM_LEN-1:0]                     fpu_rm_o,
    output logic [ROB_IDX_LEN-1:0]                 fpu_rob_idx_o,
    output logic [FLEN-1:0]                        fpu_rs1_o,
    output logic [FLEN-1:0]                        fpu_rs2_o,
    output logic [FLEN-1:0]                        fpu_rs3_o,
    input  logic                                   fpu_valid_i,
    output logic                                   fpu_ready_o,
    input  logic [ROB_IDX_LEN-1:0]                 fpu_rob_idx_i,
    input  logic [FLEN-1:0]                        fpu_result_i,
    input  logic [FFLAGS_LEN-1:0]                  fpu_fflags_i,
    output logic [NUM_REQ-1:0]                     rsp_valid_o,
    input  logic [NUM_REQ-1:0]                     rsp_ready_i,
    output logic [ROB_IDX_LEN-1:0]                 rsp_rob_idx_o,
    output logic [FLEN-1:0]                        rsp_result_o,
    output logic [FFLAGS_LEN-1:0]                  rsp_fflags_o
`ifdef LEN5_FPU_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][31:0]               stat_grant_cnt_o,
    output logic [31:0]                            stat_full_cnt_o
`endif
);

    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return sum[ID_W-1:0];
    endfunction

    logic [ID_W-1:0]                                 rr_ptr_q, rr_ptr_d;
    logic [MAX_OUTSTANDING-1:0]                      vld_q, vld_d;
    logic [MAX_OUTSTANDING-1:0][ROB_IDX_LEN-1:0]     rob_q, rob_d;
    logic [MAX_OUTSTANDING-1:0][ID_W-1:0]            id_q, id_d;
    logic [CNT_W-1:0]                                cnt_q, cnt_d;

    logic              any_valid_s;
    logic [ID_W-1:0]   grant_s;
    logic              can_issue_s;
    logic              issue_hs_s;
    logic              retire_hs_s;
    logic              free_found_s;
    logic [SLOT_W-1:0] free_slot_s;
    logic              hit_s;
    logic [SLOT_W-1:0] hit_slot_s;
    logic [ID_W-1:0]   hit_id_s;

    // Round-robin grant search from rr_ptr; depends only on valids and the pointer.
    always_comb begin
        grant_s     = rr_ptr_q;
        any_valid_s = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_valid_s && req_valid_i[wrap_idx(rr_ptr_q, i)]) begin
                grant_s     = wrap_idx(rr_ptr_q, i);
                any_valid_s = 1'b1;
            end else begin
                any_valid_s = any_valid_s;
            end
        end
    end

    // Free-slot allocation and result-tag lookup, both from registered table state.
    always_comb begin
        free_found_s = 1'b0;
        free_slot_s  = '0;
        hit_s        = 1'b0;
        hit_slot_s   = '0;
        hit_id_s     = '0;
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if (!free_found_s && !vld_q[i]) begin
                free_found_s = 1'b1;
                free_slot_s  = SLOT_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
            if (!hit_s && vld_q[i] && (rob_q[i] == fpu_rob_idx_i)) begin
                hit_s      = 1'b1;
                hit_slot_s = SLOT_W'(i);
                hit_id_s   = id_q[i];
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Issue/response handshakes and combinational outputs.
    always_comb begin
        can_issue_s   = (cnt_q < CNT_W'(MAX_OUTSTANDING)) && !flush_i;
        fpu_valid_o   = can_issue_s && any_valid_s;
        issue_hs_s    = fpu_valid_o && fpu_ready_i;
        req_ready_o   = '0;
        if (fpu_valid_o && fpu_ready_i) begin
            req_ready_o[grant_s] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
        fpu_ctl_o     = req_ctl_i[grant_s];
        fpu_rm_o      = req_rm_i[grant_s];
        fpu_rob_idx_o = req_rob_idx_i[grant_s];
        fpu_rs1_o     = req_rs1_i[grant_s];
        fpu_rs2_o     = req_rs2_i[grant_s];
        fpu_rs3_o     = req_rs3_i[grant_s];

        rsp_valid_o   = '0;
        fpu_ready_o   = 1'b1;
        retire_hs_s   = 1'b0;
        if (!flush_i && hit_s) begin
            rsp_valid_o[hit_id_s] = fpu_valid_i;
            fpu_ready_o           = rsp_ready_i[hit_id_s];
            retire_hs_s           = fpu_valid_i && rsp_ready_i[hit_id_s];
        end else begin
            fpu_ready_o = 1'b1;
        end
        rsp_rob_idx_o = fpu_rob_idx_i;
        rsp_result_o  = fpu_result_i;
        rsp_fflags_o  = fpu_fflags_i;
    end

    // Table, counter and pointer next state; flush overrides issue and retire.
    always_comb begin
        vld_d    = vld_q;
        rob_d    = rob_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        if (flush_i) begin
            vld_d = '0;
            cnt_d = '0;
        end else begin
            // Freed and allocated slots never coincide: one is valid, the other free.
            if (retire_hs_s) begin
                vld_d[hit_slot_s] = 1'b0;
            end else begin
                vld_d = vld_d;
            end
            if (issue_hs_s) begin
                vld_d[free_slot_s] = 1'b1;
                rob_d[free_slot_s] = req_rob_idx_i[grant_s];
                id_d[free_slot_s]  = grant_s;
                rr_ptr_d           = wrap_idx(grant_s, 1);
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
            cnt_d = cnt_q + CNT_W'(issue_hs_s) - CNT_W'(retire_hs_s);
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q    <= '0;
            rob_q    <= '0;
            id_q     <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            rob_q    <= rob_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef LEN5_FPU_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0]              full_cnt_q, full_cnt_d;

    // Statistics next state; counters wrap and ignore flush.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        full_cnt_d  = full_cnt_q;
        if (issue_hs_s) begin
            grant_cnt_d[grant_s] = grant_cnt_q[grant_s] + 32'd1;
        end else begin
            grant_cnt_d = grant_cnt_q;
        end
        if ((|req_valid_i) && (cnt_q == CNT_W'(MAX_OUTSTANDING))) begin
            full_cnt_d = full_cnt_q + 32'd1;
        end else begin
            full_cnt_d = full_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_cnt_q <= '0;
            full_cnt_q  <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            full_cnt_q  <= full_cnt_d;
        end
    end

    assign stat_grant_cnt_o = grant_cnt_q;
    assign stat_full_cnt_o  = full_cnt_q;
`endif

endmodule

// File: doc/fpu_issue_arbiter.md
Name: fpu_issue_arbiter

Overview:
- Shares one fpu_wrapper instance between NUM_REQ issue sources, e.g. the FP reservation station and a second FP-capable issue queue.
- Round-robin arbitration on the issue side, gated by an outstanding-operation limit.
- Tracks every in-flight operation in a small table keyed by ROB index, so results are routed back to the issuing requester even when the FPU completes out of order (e.g. DIV/SQRT overtaken by ADD).

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- MAX_OUTSTANDING, 4, tracking-table depth = max ops in flight inside the FPU (1..8).
- EU_CTL_LEN, 4, width of the FPU control field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- flush_i  in  1  pipeline flush.
- req_valid_i  in  NUM_REQ  issue valid, one per requester.
- req_ready_o  out  NUM_REQ  issue ready, one per requester.
- req_ctl_i  in  NUM_REQ x EU_CTL_LEN  per-requester control.
- req_rm_i  in  NUM_REQ x csr_pkg::FCSR_FRM_LEN  rounding mode.
- req_rob_idx_i  in  NUM_REQ x expipe_pkg::rob_idx_t  ROB tag.
- req_rs1_i / req_rs2_i / req_rs3_i  in  NUM_REQ x len5_pkg::FLEN  operands.
- fpu_valid_o  out  1  issue valid to fpu_wrapper.
- fpu_ready_i  in  1  issue ready from fpu_wrapper.
- fpu_ctl_o / fpu_rm_o / fpu_rob_idx_o / fpu_rs1_o / fpu_rs2_o / fpu_rs3_o  out  as above  granted payload.
- fpu_valid_i  in  1  result valid from fpu_wrapper.
- fpu_ready_o  out  1  result ready to fpu_wrapper.
- fpu_rob_idx_i  in  rob_idx_t  result tag.
- fpu_result_i  in  FLEN  result.
- fpu_fflags_i  in  csr_pkg::fcsr_fflags_t  result flags.
- rsp_valid_o  out  NUM_REQ  result valid per requester.
- rsp_ready_i  in  NUM_REQ  result ready per requester.
- rsp_rob_idx_o / rsp_result_o / rsp_fflags_o  out  shared  result payload (broadcast).

Behaviour:
- State:
  - rr_ptr: log2(NUM_REQ) bits.
  - Table of MAX_OUTSTANDING entries {vld, rob_idx, req_id}.
  - cnt: number of valid entries.
- Reset: all table vld=0, cnt=0, rr_ptr=0. Hence rsp_valid_o=0, fpu_valid_o=0, req_ready_o=0 while no request is pending.
- Issue path is combinational, zero added latency.
  - can_issue = (cnt < MAX_OUTSTANDING) && !flush_i.
  - Grant = first valid requester searching from rr_ptr upward, wrapping modulo NUM_REQ. Grant depends only on req_valid_i and rr_ptr, never on fpu_ready_i.
  - fpu_valid_o = can_issue && any req_valid_i.
  - Payload is muxed from the granted requester; with no valid requester it is muxed from rr_ptr.
  - req_ready_o[g] = can_issue && fpu_ready_i for granted g; 0 for all others.
- Issue handshake (fpu_valid_o && fpu_ready_i):
  - Write {1, rob_idx, g} into the lowest-index free entry, using registered state only.
  - rr_ptr <= (g+1) mod NUM_REQ. rr_ptr is unchanged when no handshake occurs.
- Response routing:
  - Lookup fpu_rob_idx_i against valid entries; lowest matching index wins. Requesters guarantee unique tags in flight.
  - Hit with id: rsp_valid_o[id] = fpu_valid_i; fpu_ready_o = rsp_ready_i[id].
  - Handshake frees the entry next cycle.
  - Miss: fpu_ready_o=1, rsp_valid_o=0, response dropped.
- rsp payload is a direct passthrough of the fpu_* result inputs.
- Simultaneous issue and retire in the same cycle:
  - Both take effect; cnt is unchanged.
  - The slot being freed is not reusable in that cycle.
  - When cnt==MAX_OUTSTANDING, a retire does not enable issue in the same cycle; can_issue rises the next cycle.
- Flush (synchronous, 1 cycle):
  - All vld <= 0, cnt <= 0, rr_ptr held.
  - During the flush cycle: req_ready_o=0, fpu_valid_o=0, rsp_valid_o=0, fpu_ready_o=1.
  - Flush takes priority over a same-cycle issue or retire.
- Reset asserted mid-operation: table cleared immediately (asynchronous). The FPU is expected to be reset by the same signal.

Optional Feature:
- Macro: LEN5_FPU_ARB_STATS_EN.
- When defined, adds outputs:
  - stat_grant_cnt_o: NUM_REQ x 32, per-requester issue-handshake counters.
  - stat_full_cnt_o: 32, cycles where any req_valid_i=1 && cnt==MAX_OUTSTANDING.
- Counters wrap at 2^32, clear on reset, and are not cleared by flush.
- When the macro is undefined, these ports and registers are absent; functional behaviour is identical.

Test Plan:
- Round-robin: req 0 and req 1 valid every cycle, fpu_ready_i=1, FPU returns in order → grants alternate 0,1,0,1; rr_ptr toggles each cycle.
- Out-of-order return: req0 issues rob 5 (DIV), req1 issues rob 9 (ADD); FPU returns 9 then 5 → rsp_valid_o=2'b10 with rob 9, then 2'b01 with rob 5.
- Full table: 4 issues with no responses → fpu_valid_o=0 and req_ready_o=0 on the 5th cycle. One retire → issue resumes the following cycle; cnt stays 4.
- Backpressure: result for req1 with rsp_ready_i[1]=0 for 3 cycles → fpu_ready_o=0 for those 3 cycles; entry retained; freed after the handshake.
- Flush with 3 in flight → cnt=0 next cycle. A stale result for rob 7 arriving afterwards is dropped: fpu_ready_o=1, rsp_valid_o=0.
- Stats (LEN5_FPU_ARB_STATS_EN defined): 10 grants to req0 and 6 to req1 → stat_grant_cnt_o = {6,10}. Counts survive a flush and clear on rst_i.
